// File: rtl/fft_twiddle_mult.sv
// Streaming complex twiddle multiplier: 4-cycle accept-to-output latency, tags samples with a ROM index.
// A stalled output freezes every stage; define TWIDDLE_CONJ_EN to conjugate the twiddle (inverse FFT).
module fft_twiddle_mult #(
  parameter int data_width    = 16,
  parameter int address_width = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sof,
  input  logic signed [data_width-1:0] in_re,
  input  logic signed [data_width-1:0] in_im,
  output logic [address_width-1:0]     rom_addr,
  input  logic signed [data_width-1:0] rom_datar,
  input  logic signed [data_width-1:0] rom_datai,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [data_width-1:0] out_re,
  output logic signed [data_width-1:0] out_im,
  output logic                         out_last
);

  localparam int DW = data_width;
  localparam int AW = address_width;
  localparam int PW = 2 * data_width;
  localparam int SW = 2 * data_width + 1;

  localparam logic signed [DW-1:0] TW_MAX  = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] TW_MIN  = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [SW-1:0] SAT_MAX = SW'(TW_MAX);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(TW_MIN);
  localparam logic signed [SW-1:0] RND     = SW'(2 ** (data_width - 2));

  logic          stall;
  logic          accept;
  logic [AW-1:0] idx_q, idx_d, tag_d;

  logic                 s1_vld_q, s2_vld_q, s3_vld_q;
  logic signed [DW-1:0] s1_re_q, s1_im_q, s2_re_q, s2_im_q;
  logic [AW-1:0]        s1_tag_q, s2_tag_q;
  logic                 s3_last_q;
  logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;

  logic                 out_valid_q, out_last_q;
  logic signed [DW-1:0] out_re_q, out_im_q, out_re_d, out_im_d;
  logic signed [SW-1:0] re_sum, im_sum;
  logic signed [DW-1:0] tw_im;

  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  // While stalled, re-read the S2 tag so the registered ROM output keeps matching S2.
  assign rom_addr = stall ? s2_tag_q : s1_tag_q;

`ifdef TWIDDLE_CONJ_EN
  assign tw_im = (rom_datai == TW_MIN) ? TW_MAX : -rom_datai;
`else
  assign tw_im = rom_datai;
`endif

  function automatic logic signed [DW-1:0] sat_round(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] r;
    r = (v + RND) >>> (DW - 1);
    if (r > SAT_MAX)      sat_round = TW_MAX;
    else if (r < SAT_MIN) sat_round = TW_MIN;
    else                  sat_round = r[DW-1:0];
  endfunction

  always_comb begin
    tag_d    = in_sof ? '0 : idx_q;
    idx_d    = tag_d + AW'(1);
    re_sum   = SW'(p_rr_q) - SW'(p_ii_q);
    im_sum   = SW'(p_ri_q) + SW'(p_ir_q);
    out_re_d = sat_round(re_sum);
    out_im_d = sat_round(im_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      s1_vld_q    <= 1'b0;
      s1_re_q     <= '0;
      s1_im_q     <= '0;
      s1_tag_q    <= '0;
      s2_vld_q    <= 1'b0;
      s2_re_q     <= '0;
      s2_im_q     <= '0;
      s2_tag_q    <= '0;
      s3_vld_q    <= 1'b0;
      s3_last_q   <= 1'b0;
      p_rr_q      <= '0;
      p_ii_q      <= '0;
      p_ri_q      <= '0;
      p_ir_q      <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_last_q  <= 1'b0;
    end else if (!stall) begin
      if (accept) begin
        idx_q    <= idx_d;
        s1_re_q  <= in_re;
        s1_im_q  <= in_im;
        s1_tag_q <= tag_d;
      end
      s1_vld_q <= accept;

      if (s1_vld_q) begin
        s2_re_q  <= s1_re_q;
        s2_im_q  <= s1_im_q;
        s2_tag_q <= s1_tag_q;
      end
      s2_vld_q <= s1_vld_q;

      if (s2_vld_q) begin
        p_rr_q    <= PW'(s2_re_q) * PW'(rom_datar);
        p_ii_q    <= PW'(s2_im_q) * PW'(tw_im);
        p_ri_q    <= PW'(s2_re_q) * PW'(tw_im);
        p_ir_q    <= PW'(s2_im_q) * PW'(rom_datar);
        s3_last_q <= (s2_tag_q == {AW{1'b1}});
      end
      s3_vld_q <= s2_vld_q;

      // Output data holds through bubbles; only a valid S3 overwrites it.
      if (s3_vld_q) begin
        out_re_q   <= out_re_d;
        out_im_q   <= out_im_d;
        out_last_q <= s3_last_q;
      end
      out_valid_q <= s3_vld_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_last  = out_last_q;

endmodule
